// File: rtl/mbus_member_ctrl_driver.sv
// Layer-side driver for the MBus member controller: prefix enumeration,
// invalidation, sleep handshake and wakeup/interrupt request sequencing.
module mbus_member_ctrl_driver #(
  parameter int PULSE_CYC   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enum_req,
  input  logic [3:0] i_enum_addr,
  input  logic       i_inval_req,
  input  logic       i_sleep_cmd,
  input  logic       i_tx_pend,
  input  logic       i_int_ack,
  input  logic       i_external_int,
  input  logic       i_mbc_sleep,
  input  logic       i_addr_valid,
  input  logic [3:0] i_addr_out,
  output logic       o_sleep_req,
  output logic       o_wakeup_req,
  output logic       o_clr_ext_int,
  output logic       o_addr_wr_en,
  output logic       o_addr_clr_b,
  output logic [3:0] o_addr_in,
  output logic       o_busy,
  output logic       o_cmd_done,
  output logic       o_cmd_err,
  output logic       o_int_sync
);

  localparam int PW = $clog2(PULSE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, A_SETUP, A_WR, A_CHK, C_LOW, C_CHK, S_WAIT
  } state_t;

  logic [6:0] r_sync [SYNC_STAGES];
  logic [6:0] w_async;
  logic [6:0] w_s;

  assign w_async = {i_external_int, i_mbc_sleep, i_addr_valid, i_addr_out};
  assign w_s     = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= w_async;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  state_t          r_state, w_state_n;
  logic [PW-1:0]   r_pcnt, w_pcnt_n;
  logic [TW-1:0]   r_tcnt, w_tcnt_n;
  logic            w_done_n, w_err_n, w_latch, w_req_any;
  logic            w_tmo;
  logic            r_busy, r_wr, r_clrb, r_sreq, r_done, r_err;
  logic [3:0]      r_addr_in;

  assign w_req_any = i_inval_req | i_enum_req | i_sleep_cmd;
  assign w_tmo     = (r_tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    w_state_n = r_state;
    w_pcnt_n  = '0;
    w_tcnt_n  = '0;
    w_done_n  = 1'b0;
    w_err_n   = (r_state != IDLE) && w_req_any;
    w_latch   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_inval_req) begin
          w_state_n = C_LOW;
          w_err_n   = i_enum_req | i_sleep_cmd;
        end else if (i_enum_req) begin
          w_state_n = A_SETUP;
          w_latch   = 1'b1;
          w_err_n   = i_sleep_cmd;
        end else if (i_sleep_cmd) begin
          w_state_n = S_WAIT;
        end
      end
      A_SETUP: w_state_n = A_WR;
      A_WR: begin
        if (r_pcnt == PW'(PULSE_CYC - 1)) w_state_n = A_CHK;
        else w_pcnt_n = r_pcnt + 1'b1;
      end
      C_LOW: begin
        if (r_pcnt == PW'(PULSE_CYC - 1)) w_state_n = C_CHK;
        else w_pcnt_n = r_pcnt + 1'b1;
      end
      A_CHK, C_CHK, S_WAIT: begin
        // success wins over a timeout landing on the same cycle
        if ((r_state == A_CHK && w_s[4] && w_s[3:0] == r_addr_in) ||
            (r_state == C_CHK && !w_s[4]) ||
            (r_state == S_WAIT && w_s[5])) begin
          w_state_n = IDLE;
          w_done_n  = 1'b1;
        end else if (w_tmo) begin
          w_state_n = IDLE;
          w_err_n   = 1'b1;
        end else begin
          w_tcnt_n = r_tcnt + 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_pcnt    <= '0;
      r_tcnt    <= '0;
      r_busy    <= 1'b0;
      r_wr      <= 1'b0;
      r_clrb    <= 1'b1;
      r_sreq    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_addr_in <= 4'hF;
    end else begin
      r_state <= w_state_n;
      r_pcnt  <= w_pcnt_n;
      r_tcnt  <= w_tcnt_n;
      r_busy  <= (w_state_n != IDLE);
      r_wr    <= (w_state_n == A_WR);
      r_clrb  <= (w_state_n != C_LOW);
      r_sreq  <= (w_state_n == S_WAIT);
      r_done  <= w_done_n;
      r_err   <= w_err_n;
      if (w_latch) r_addr_in <= i_enum_addr;
    end
  end

  logic          r_tx_d, r_wake, r_clr, r_clr_d;
  logic [PW-1:0] r_ccnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_d  <= 1'b0;
      r_wake  <= 1'b0;
      r_clr   <= 1'b0;
      r_clr_d <= 1'b0;
      r_ccnt  <= '0;
    end else begin
      r_tx_d  <= i_tx_pend;
      r_clr_d <= r_clr;
      if (i_int_ack) begin
        r_clr  <= 1'b1;
        r_ccnt <= '0;
      end else if (r_clr) begin
        if (r_ccnt != PW'(PULSE_CYC - 1)) r_ccnt <= r_ccnt + 1'b1;
        else if (!w_s[6]) r_clr <= 1'b0;
      end
      if (i_int_ack) r_wake <= 1'b0;
      else if ((i_tx_pend && !r_tx_d) ||
               (r_clr_d && !r_clr && i_tx_pend)) r_wake <= 1'b1;
    end
  end

  assign o_sleep_req   = r_sreq;
  assign o_wakeup_req  = r_wake;
  assign o_clr_ext_int = r_clr;
  assign o_addr_wr_en  = r_wr;
  assign o_addr_clr_b  = r_clrb;
  assign o_addr_in     = r_addr_in;
  assign o_busy        = r_busy;
  assign o_cmd_done    = r_done;
  assign o_cmd_err     = r_err;
  assign o_int_sync    = w_s[6];

endmodule

// File: tb/tb_mbus_member_ctrl_driver.sv
// Directed bench for mbus_member_ctrl_driver: cycle table plus
// hand-written sleep, timeout, interrupt and reset sequences.
module tb_mbus_member_ctrl_driver;

  localparam int P  = 4;
  localparam int SS = 2;
  localparam int T  = 1023;

  logic       clk = 0;
  logic       rst, enq, inv, slp, txp, ack, ext, mbs, av;
  logic [3:0] ea, ao;
  logic       sreq, wake, clr, wr, clrb, busy, done, err, isync;
  logic [3:0] ain;

  mbus_member_ctrl_driver #(.PULSE_CYC(P), .SYNC_STAGES(SS), .TIMEOUT(T)) dut (
    .i_clk(clk), .i_reset(rst), .i_enum_req(enq), .i_enum_addr(ea),
    .i_inval_req(inv), .i_sleep_cmd(slp), .i_tx_pend(txp), .i_int_ack(ack),
    .i_external_int(ext), .i_mbc_sleep(mbs), .i_addr_valid(av),
    .i_addr_out(ao), .o_sleep_req(sreq), .o_wakeup_req(wake),
    .o_clr_ext_int(clr), .o_addr_wr_en(wr), .o_addr_clr_b(clrb),
    .o_addr_in(ain), .o_busy(busy), .o_cmd_done(done), .o_cmd_err(err),
    .o_int_sync(isync)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       inv, en;
    logic [3:0] ea;
    logic       slp, av;
    logic [3:0] ao;
    logic       wr, clrb, sreq, busy, done, err;
    logic [3:0] ain;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k, kend, cnt, lows, dones;
    // row i: inputs held in cycle i, outputs expected in cycle i+1
    tbl[0]  = '{0,1,4'h5,0,0,4'h0, 0,1,0,1,0,0,4'h5};
    tbl[1]  = '{0,0,4'h0,0,0,4'h0, 1,1,0,1,0,0,4'h5};
    tbl[2]  = '{0,0,4'h0,0,0,4'h0, 1,1,0,1,0,0,4'h5};
    tbl[3]  = '{0,0,4'h0,0,0,4'h0, 1,1,0,1,0,0,4'h5};
    tbl[4]  = '{0,0,4'h0,0,0,4'h0, 1,1,0,1,0,0,4'h5};
    tbl[5]  = '{0,0,4'h0,0,1,4'h5, 0,1,0,1,0,0,4'h5};
    tbl[6]  = '{0,0,4'h0,0,1,4'h5, 0,1,0,1,0,0,4'h5};
    tbl[7]  = '{0,0,4'h0,0,1,4'h5, 0,1,0,0,1,0,4'h5};
    tbl[8]  = '{0,0,4'h0,0,1,4'h5, 0,1,0,0,0,0,4'h5};
    tbl[9]  = '{1,1,4'hA,0,1,4'h5, 0,0,0,1,0,1,4'h5};
    tbl[10] = '{0,0,4'h0,1,1,4'h5, 0,0,0,1,0,1,4'h5};
    tbl[11] = '{0,0,4'h0,0,1,4'h5, 0,0,0,1,0,0,4'h5};
    tbl[12] = '{0,0,4'h0,0,1,4'h5, 0,0,0,1,0,0,4'h5};
    tbl[13] = '{0,0,4'h0,0,0,4'h5, 0,1,0,1,0,0,4'h5};
    tbl[14] = '{0,0,4'h0,0,0,4'h5, 0,1,0,1,0,0,4'h5};
    tbl[15] = '{0,0,4'h0,0,0,4'h5, 0,1,0,0,1,0,4'h5};
    tbl[16] = '{0,0,4'h0,0,0,4'h5, 0,1,0,0,0,0,4'h5};

    rst = 1; enq = 0; inv = 0; slp = 0; txp = 0; ack = 0;
    ext = 0; mbs = 0; av = 0; ea = 0; ao = 0;
    step(); step();
    chk("rst sleep_req", sreq, 0);
    chk("rst wakeup", wake, 0);
    chk("rst clr_ext", clr, 0);
    chk("rst wr_en", wr, 0);
    chk("rst clr_b", clrb, 1);
    chk("rst addr_in", ain, 4'hF);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst int_sync", isync, 0);
    rst = 0;
    step();

    // enumeration, then inval+enum collision and sleep while busy
    for (int i = 0; i < 17; i++) begin
      inv = tbl[i].inv; enq = tbl[i].en; ea = tbl[i].ea;
      slp = tbl[i].slp; av = tbl[i].av; ao = tbl[i].ao;
      step();
      chk($sformatf("row%0d wr_en", i), wr, tbl[i].wr);
      chk($sformatf("row%0d clr_b", i), clrb, tbl[i].clrb);
      chk($sformatf("row%0d sleep_req", i), sreq, tbl[i].sreq);
      chk($sformatf("row%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("row%0d done", i), done, tbl[i].done);
      chk($sformatf("row%0d err", i), err, tbl[i].err);
      chk($sformatf("row%0d addr_in", i), ain, tbl[i].ain);
    end
    inv = 0; enq = 0; slp = 0;

    // sleep: MBC_SLEEP rises 10 cycles after the command
    slp = 1;
    step();
    slp = 0;
    kend = 0;
    for (int j = 1; j <= 40; j++) begin
      if (!sreq) begin
        kend = j;
        chk("sleep done with req drop", done, 1);
        chk("sleep busy after", busy, 0);
        break;
      end
      if (j == 10) mbs = 1;
      step();
    end
    chk("sleep req drop cycle", kend, 10 + SS + 1);
    mbs = 0;
    step(); step(); step();

    // invalidation with ADDR_VALID stuck high -> timeout
    av = 1; ao = 4'h5;
    step(); step(); step();
    inv = 1;
    step();
    inv = 0;
    kend = 0; lows = 0; dones = 0;
    for (int j = 1; j <= 1100; j++) begin
      if (!clrb) lows++;
      if (done) dones++;
      if (err) begin
        kend = j;
        chk("tmo clr_b high", clrb, 1);
        chk("tmo busy low", busy, 0);
        break;
      end
      step();
    end
    chk("tmo err cycle", kend, 1 + P + T);
    chk("tmo clr_b low cycles", lows, P);
    chk("tmo no done", dones, 0);
    av = 0;
    step(); step(); step();

    // wakeup / interrupt acknowledge
    txp = 1;
    step();
    chk("wake set", wake, 1);
    step(); step(); step(); step();
    ext = 1;
    step(); step(); step(); step(); step();
    chk("int_sync high", isync, 1);
    ack = 1;
    step();
    ack = 0;
    chk("wake clr after ack", wake, 0);
    cnt = 0; kend = 0;
    for (int j = 1; j <= 60; j++) begin
      if (!clr) begin
        kend = j;
        chk("wake low at clr fall", wake, 0);
        break;
      end
      cnt++;
      if (j == 8) ext = 0;
      step();
    end
    chk("clr_ext high cycles", cnt, 8 + SS);
    step();
    chk("wake reassert", wake, 1);

    // INT_ACK during CLR_EXT_INT restarts its minimum width
    txp = 0;
    step(); step(); step();
    ack = 1;
    step();
    ack = 0;
    step();
    ack = 1;
    step();
    ack = 0;
    cnt = 2;
    for (int j = 0; j < 30; j++) begin
      if (!clr) break;
      cnt++;
      step();
    end
    chk("clr_ext restart cycles", cnt, P + 2);

    // reset in the middle of A_WR
    step(); step();
    ea = 4'h3; enq = 1;
    step();
    enq = 0;
    step();
    chk("mid wr_en high", wr, 1);
    chk("mid addr_in", ain, 4'h3);
    rst = 1;
    step();
    chk("rst wr_en low", wr, 0);
    chk("rst addr_in F", ain, 4'hF);
    chk("rst busy low", busy, 0);
    chk("rst clr_b high", clrb, 1);
    rst = 0;
    dones = 0; lows = 0;
    for (int j = 0; j < 20; j++) begin
      if (done) dones++;
      if (wr) lows++;
      step();
    end
    chk("post rst no done", dones, 0);
    chk("post rst no wr_en", lows, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
